rho_inverse_lane_unit: RTL and testbench

Streaming inverse-rho stage for the Keccak-f[1600] permutation datapath: accepts the 25 lanes of one state, one 64-bit lane per transfer, and rotates each lane right by its rho offset, undoing the left rotation applied on the forward side. The block tracks the lane index internally, tags each output lane with its index and (x, y) coordinates, and marks the last lane of the state. It sits between the state buffer and the inverse-permutation logic, behind a valid/ready handshake on both sides.

---
 rtl/rho_inverse_lane_unit_if.sv | 23 ++
 rtl/rho_inverse_lane_unit.sv | 98 +++++++++
 tb/tb_rho_inverse_lane_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/rho_inverse_lane_unit_if.sv
// rtl/rho_inverse_lane_unit_if.sv - lane-in / lane-out handshake bundle for the inverse-rho stage
interface rho_inverse_lane_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_lane;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_lane;
  logic [4:0]  out_idx;
  logic [2:0]  out_x;
  logic [2:0]  out_y;
  logic        out_last;

  modport master (
    output in_valid, in_lane, out_ready,
    input  in_ready, out_valid, out_lane, out_idx, out_x, out_y, out_last
  );

  modport slave (
    input  in_valid, in_lane, out_ready,
    output in_ready, out_valid, out_lane, out_idx, out_x, out_y, out_last
  );
endinterface

// File: rtl/rho_inverse_lane_unit.sv
// rtl/rho_inverse_lane_unit.sv - streaming Keccak inverse-rho: rotate each lane right by its rho offset
module rho_inverse_lane_unit (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  rho_inverse_lane_unit_if.slave  bus
);
  logic [4:0]  cnt;
  logic [5:0]  off;
  logic [4:0]  col;
  logic [4:0]  row;
  logic [2:0]  x_nxt;
  logic [2:0]  y_nxt;
  logic [63:0] rot;
  logic        accept;

  logic        out_valid_q;
  logic [63:0] out_lane_q;
  logic [4:0]  out_idx_q;
  logic [2:0]  out_x_q;
  logic [2:0]  out_y_q;
  logic        out_last_q;

  always_comb begin
    off = 6'd0;
    case (cnt)
      5'd0:  off = 6'd21;
      5'd1:  off = 6'd8;
      5'd2:  off = 6'd41;
      5'd3:  off = 6'd45;
      5'd4:  off = 6'd15;
      5'd5:  off = 6'd56;
      5'd6:  off = 6'd14;
      5'd7:  off = 6'd18;
      5'd8:  off = 6'd2;
      5'd9:  off = 6'd61;
      5'd10: off = 6'd28;
      5'd11: off = 6'd27;
      5'd12: off = 6'd0;
      5'd13: off = 6'd1;
      5'd14: off = 6'd62;
      5'd15: off = 6'd55;
      5'd16: off = 6'd20;
      5'd17: off = 6'd36;
      5'd18: off = 6'd44;
      5'd19: off = 6'd6;
      5'd20: off = 6'd25;
      5'd21: off = 6'd39;
      5'd22: off = 6'd3;
      5'd23: off = 6'd10;
      5'd24: off = 6'd43;
      default: off = 6'd0;
    endcase
  end

  // A left shift by 64 (offset 0) yields zero, so offset 0 degenerates to a pass-through.
  assign rot = (bus.in_lane >> off) | (bus.in_lane << (7'd64 - {1'b0, off}));

  assign col   = cnt % 5'd5;
  assign row   = cnt / 5'd5;
  assign x_nxt = (col >= 5'd2) ? 3'(col - 5'd2) : 3'(col + 5'd3);
  assign y_nxt = (row >= 5'd2) ? 3'(row - 5'd2) : 3'(row + 5'd3);

  assign bus.in_ready = !clear && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= 5'd0;
      out_valid_q <= 1'b0;
      out_lane_q  <= 64'd0;
      out_idx_q   <= 5'd0;
      out_x_q     <= 3'd0;
      out_y_q     <= 3'd0;
      out_last_q  <= 1'b0;
    end else if (clear) begin
      cnt         <= 5'd0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      cnt         <= (cnt == 5'd24) ? 5'd0 : cnt + 5'd1;
      out_valid_q <= 1'b1;
      out_lane_q  <= rot;
      out_idx_q   <= cnt;
      out_x_q     <= x_nxt;
      out_y_q     <= y_nxt;
      out_last_q  <= (cnt == 5'd24);
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_lane  = out_lane_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_rho_inverse_lane_unit.sv
// tb/tb_rho_inverse_lane_unit.sv - directed vector bench for the inverse-rho lane stage
module tb_rho_inverse_lane_unit;
  logic clk;
  logic rst_n;
  logic clear;

  rho_inverse_lane_unit_if bus ();

  rho_inverse_lane_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [63:0] lane;
    logic [63:0] exp_lane;
    logic [2:0]  exp_x;
    logic [2:0]  exp_y;
    logic        exp_last;
  } vec_t;

  vec_t vecs[7];
  int   offs[25];
  int   checks;
  int   errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] v, input int o);
    logic [63:0] r;
    for (int k = 0; k < 64; k++) r[k] = v[(k + o) % 64];
    return r;
  endfunction

  function automatic logic [63:0] rotl(input logic [63:0] v, input int o);
    logic [63:0] r;
    for (int k = 0; k < 64; k++) r[(k + o) % 64] = v[k];
    return r;
  endfunction

  task automatic do_clear();
    clear = 1'b1;
    bus.in_valid = 1'b0;
    step();
    clear = 1'b0;
  endtask

  task automatic send(input logic [63:0] lane);
    bus.in_valid = 1'b1;
    bus.in_lane  = lane;
    step();
    bus.in_valid = 1'b0;
  endtask

  logic [63:0] held;
  logic [63:0] l3;
  logic [63:0] orig;

  initial begin
    offs = '{21, 8, 41, 45, 15, 56, 14, 18, 2, 61, 28, 27, 0, 1, 62, 55, 20, 36, 44, 6, 25, 39, 3, 10, 43};
    vecs[0] = '{0,  64'h0000_0000_0020_0000, 64'h1,                   3'd3, 3'd3, 1'b0};
    vecs[1] = '{2,  64'h0000_0200_0000_0000, 64'h1,                   3'd0, 3'd3, 1'b0};
    vecs[2] = '{7,  64'h1,                   64'h0000_4000_0000_0000, 3'd0, 3'd4, 1'b0};
    vecs[3] = '{12, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 3'd0, 3'd0, 1'b0};
    vecs[4] = '{13, 64'h1,                   64'h8000_0000_0000_0000, 3'd1, 3'd0, 1'b0};
    vecs[5] = '{14, 64'h4000_0000_0000_0000, 64'h1,                   3'd2, 3'd0, 1'b0};
    vecs[6] = '{24, 64'h0000_0800_0000_0000, 64'h1,                   3'd2, 3'd2, 1'b1};
    checks = 0;
    errors = 0;

    rst_n = 1'b1;
    clear = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_lane   = 64'd0;
    bus.out_ready = 1'b1;

    // Reset asserted mid-stream: outputs must clear immediately, without a clock edge.
    #2 rst_n = 1'b0;
    #10 rst_n = 1'b1;
    step();
    send(64'h1234_5678_9ABC_DEF0);
    send(64'h0F0F_0F0F_0F0F_0F0F);
    bus.in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_lane",  bus.out_lane,       64'd0);
    chk("rst_out_idx",   64'(bus.out_idx),   64'd0);
    chk("rst_out_x",     64'(bus.out_x),     64'd0);
    chk("rst_out_y",     64'(bus.out_y),     64'd0);
    chk("rst_out_last",  64'(bus.out_last),  64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    send(64'h0000_0000_0020_0000);
    chk("rst_next_idx",  64'(bus.out_idx),  64'd0);
    chk("rst_next_lane", bus.out_lane,      64'h1);

    // Table vectors: advance the counter with filler lanes, then present the vector lane.
    for (int v = 0; v < 7; v++) begin
      do_clear();
      for (int f = 0; f < vecs[v].idx; f++) send(64'(f));
      send(vecs[v].lane);
      chk($sformatf("vec%0d_valid", vecs[v].idx), 64'(bus.out_valid), 64'd1);
      chk($sformatf("vec%0d_lane",  vecs[v].idx), bus.out_lane,        vecs[v].exp_lane);
      chk($sformatf("vec%0d_idx",   vecs[v].idx), 64'(bus.out_idx),    64'(vecs[v].idx));
      chk($sformatf("vec%0d_x",     vecs[v].idx), 64'(bus.out_x),      64'(vecs[v].exp_x));
      chk($sformatf("vec%0d_y",     vecs[v].idx), 64'(bus.out_y),      64'(vecs[v].exp_y));
      chk($sformatf("vec%0d_last",  vecs[v].idx), 64'(bus.out_last),   64'(vecs[v].exp_last));
    end

    // 50 back-to-back lanes: two full states with wrap and no bubbles.
    do_clear();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      bus.in_valid = 1'b1;
      bus.in_lane  = {32'(i * 32'h9E37_79B9), 32'(i + 7)};
      #1;
      chk($sformatf("wrap%0d_in_ready", i), 64'(bus.in_ready), 64'd1);
      step();
      chk($sformatf("wrap%0d_valid", i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("wrap%0d_idx", i),   64'(bus.out_idx),   64'(i % 25));
      chk($sformatf("wrap%0d_x", i),     64'(bus.out_x),     64'(((i % 5) + 3) % 5));
      chk($sformatf("wrap%0d_y", i),     64'(bus.out_y),     64'((((i % 25) / 5) + 3) % 5));
      chk($sformatf("wrap%0d_last", i),  64'(bus.out_last),  64'((i % 25) == 24));
      chk($sformatf("wrap%0d_lane", i),  bus.out_lane,
          rotr({32'(i * 32'h9E37_79B9), 32'(i + 7)}, offs[i % 25]));
    end
    bus.in_valid = 1'b0;
    step();
    chk("wrap_drain_valid", 64'(bus.out_valid), 64'd0);

    // Backpressure: lane idx2 held for 5 stalled cycles, lane idx3 waits at the input.
    do_clear();
    send(64'hA);
    send(64'hB);
    send(64'h0000_0200_0000_0000);
    held = bus.out_lane;
    chk("bp_held_lane", held, 64'h1);
    l3 = 64'hCAFE_F00D_1357_9BDF;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_lane   = l3;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_in_ready", c), 64'(bus.in_ready),  64'd0);
      step();
      chk($sformatf("bp%0d_valid", c),    64'(bus.out_valid), 64'd1);
      chk($sformatf("bp%0d_idx", c),      64'(bus.out_idx),   64'd2);
      chk($sformatf("bp%0d_lane", c),     bus.out_lane,       held);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    chk("bp_after_idx",  64'(bus.out_idx), 64'd3);
    chk("bp_after_lane", bus.out_lane,     rotr(l3, 45));
    step();
    chk("bp_after_drain", 64'(bus.out_valid), 64'd0);

    // clear mid-state with a concurrent input: the lane is dropped and counting restarts.
    do_clear();
    for (int f = 0; f < 7; f++) send(64'(f + 100));
    clear = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_lane  = 64'hFFFF_0000_FFFF_0000;
    #1;
    chk("clr_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    clear = 1'b0;
    bus.in_valid = 1'b0;
    chk("clr_out_valid", 64'(bus.out_valid), 64'd0);
    send(64'h0000_0000_0020_0000);
    chk("clr_next_idx",  64'(bus.out_idx), 64'd0);
    chk("clr_next_lane", bus.out_lane,     64'h1);

    // Round trip: model rotates left, DUT must restore the original lane.
    do_clear();
    for (int i = 0; i < 25; i++) begin
      orig = {$urandom, $urandom};
      send(rotl(orig, offs[i]));
      chk($sformatf("rt%0d_idx", i),  64'(bus.out_idx), 64'(i));
      chk($sformatf("rt%0d_lane", i), bus.out_lane,     orig);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
